// File: rtl/pairing_io_seq.sv
// pairing_io_seq: 32-bit word-stream sequencer around the duursma_lee_algo Tate-pairing core.
// Define PAIRING_TRIT_CHECK_EN to reject operands that carry illegal trit codes.
`ifndef WIDTH
`define WIDTH 193
`endif
`ifndef W6
`define W6 1163
`endif

module pairing_io_seq #(
  parameter int WORD_W     = 32,
  parameter int ELEM_WORDS = 7,
  parameter int IN_WORDS   = 28,
  parameter int OUT_WORDS  = 42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic [`WIDTH:0]   core_xp,
  output logic [`WIDTH:0]   core_yp,
  output logic [`WIDTH:0]   core_xr,
  output logic [`WIDTH:0]   core_yr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [`W6:0]      core_out
);

  localparam int          EW        = `WIDTH + 1;
  localparam logic [2:0]  LAST_WORD = 3'(ELEM_WORDS - 1);
  localparam logic [4:0]  IN_LAST   = 5'(IN_WORDS - 1);
  localparam logic [5:0]  OUT_LAST  = 6'(OUT_WORDS - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      in_cnt;
  logic [1:0]      in_elem;
  logic [2:0]      in_word;
  logic [5:0]      out_cnt;
  logic [2:0]      out_elem;
  logic [2:0]      out_word;
  logic            done_q;
  logic            done_rise;
  logic            in_fire, in_last;
  logic            out_fire, out_last;
  logic            op_bad;
  logic [`WIDTH:0] opnd_q [4];
  logic [`WIDTH:0] res_q  [6];
  logic [`WIDTH:0] cur_elem;

  assign in_fire   = in_valid && (state_q == S_LOAD);
  assign in_last   = (in_cnt == IN_LAST);
  assign out_fire  = out_ready && (state_q == S_UNLOAD);
  assign out_last  = (out_cnt == OUT_LAST);
  assign done_rise = core_done && !done_q;

  assign core_xp = opnd_q[0];
  assign core_yp = opnd_q[1];
  assign core_xr = opnd_q[2];
  assign core_yr = opnd_q[3];

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_start = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_fire && in_last) state_d = op_bad ? S_LOAD : S_START;
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) state_d = S_UNLOAD;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (!reset) begin
      state_q  <= S_LOAD;
      in_cnt   <= '0;
      in_elem  <= '0;
      in_word  <= '0;
      out_cnt  <= '0;
      out_elem <= '0;
      out_word <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= core_done;
      if (in_fire) begin
        if (in_last) begin
          in_cnt  <= '0;
          in_elem <= '0;
          in_word <= '0;
        end else begin
          in_cnt <= in_cnt + 5'd1;
          if (in_word == LAST_WORD) begin
            in_word <= '0;
            in_elem <= in_elem + 2'd1;
          end else begin
            in_word <= in_word + 3'd1;
          end
        end
      end
      if (out_fire) begin
        if (out_last) begin
          out_cnt  <= '0;
          out_elem <= '0;
          out_word <= '0;
        end else begin
          out_cnt <= out_cnt + 6'd1;
          if (out_word == LAST_WORD) begin
            out_word <= '0;
            out_elem <= out_elem + 3'd1;
          end else begin
            out_word <= out_word + 3'd1;
          end
        end
      end
    end
  end

  // Operand registers only change on an accepted LOAD word, so they hold through START/WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int e = 0; e < 4; e++) opnd_q[e] <= '0;
    end else if (in_fire) begin
      for (int k = 0; k < ELEM_WORDS - 1; k++)
        if (in_word == 3'(k)) opnd_q[in_elem][k*WORD_W +: WORD_W] <= in_data;
      if (in_word == LAST_WORD) opnd_q[in_elem][`WIDTH -: 2] <= in_data[1:0];
    end
  end

  // NOTE: the result store is pure datapath with no reset; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (reset && state_q == S_WAIT && done_rise) begin
      for (int e = 0; e < 6; e++) res_q[e] <= core_out[e*EW +: EW];
    end
  end

  always_comb begin
    cur_elem = res_q[0];
    for (int e = 1; e < 6; e++)
      if (out_elem == 3'(e)) cur_elem = res_q[e];
    out_data = '0;
    for (int k = 0; k < ELEM_WORDS - 1; k++)
      if (out_word == 3'(k)) out_data = cur_elem[k*WORD_W +: WORD_W];
    if (out_word == LAST_WORD) out_data = {{(WORD_W-2){1'b0}}, cur_elem[`WIDTH -: 2]};
  end

`ifdef PAIRING_TRIT_CHECK_EN
  logic word_bad, bad_q, err_q;

  always_comb begin
    word_bad = 1'b0;
    for (int i = 0; i < WORD_W / 2; i++)
      if (in_data[2*i +: 2] == 2'b11) word_bad = 1'b1;
    if (in_word == LAST_WORD && in_data[WORD_W-1:2] != '0) word_bad = 1'b1;
  end

  // The first word of an operation restarts both the running violation flag and err.
  assign op_bad = bad_q || word_bad;
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (in_fire) begin
      if (in_cnt == '0) begin
        bad_q <= word_bad;
        err_q <= 1'b0;
      end else begin
        bad_q <= op_bad;
      end
      if (in_last && op_bad) err_q <= 1'b1;
    end
  end
`else
  assign op_bad = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_pairing_io_seq.sv
// Scoreboard bench for pairing_io_seq: a stand-in core drives core_done/core_out, expected words are queued
// when the result is presented, and a monitor compares every output handshake against the queue.
module tb_pairing_io_seq;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err;
  logic [193:0]  core_xp, core_yp, core_xr, core_yr;
  logic          core_start;
  logic          core_done;
  logic [1163:0] core_out;

  always #5 clk = ~clk;

  pairing_io_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err),
    .core_xp    (core_xp),
    .core_yp    (core_yp),
    .core_xr    (core_xr),
    .core_yr    (core_yr),
    .core_start (core_start),
    .core_done  (core_done),
    .core_out   (core_out)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          start_cnt = 0;
  int          hs_cnt    = 0;
  int          ready_mode = 0;
  logic [31:0] exp_q [$];
  logic [31:0] in_words  [28];
  logic [31:0] res_words [42];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operand words use only trit codes 00/01/10; word 6 carries two bits.
  function automatic logic [31:0] opnd_word(input int e, input int w, input logic [3:0] s);
    logic [3:0] dig [7];
    logic [3:0] de  [4];
    dig = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8};
    de  = '{4'h1, 4'h2, 4'h4, 4'h5};
    if (w == 6) return {30'b0, (e % 2 == 1) ? 2'b10 : 2'b01};
    return {8'hA5, de[e], dig[w], s, s, 8'h12};
  endfunction

  task automatic set_operands(input logic [3:0] s);
    for (int e = 0; e < 4; e++)
      for (int w = 0; w < 7; w++) in_words[e*7+w] = opnd_word(e, w, s);
  endtask

  task automatic set_results(input logic [31:0] seed);
    for (int i = 0; i < 42; i++) res_words[i] = (32'h9E3779B9 * (i + 7)) ^ seed;
  endtask

  function automatic logic [193:0] pack_elem(input int e);
    logic [193:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) v[k*32 +: 32] = in_words[e*7+k];
    v[193:192] = in_words[e*7+6][1:0];
    return v;
  endfunction

  function automatic logic [1163:0] build_out();
    logic [1163:0] v;
    v = '0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 6; k++) v[e*194 + k*32 +: 32] = res_words[e*7+k];
      v[e*194 + 192 +: 2] = res_words[e*7+6][1:0];
    end
    return v;
  endfunction

  // Monitor: counts core_start cycles, checks held data during stalls, scores every handshake.
  initial begin
    logic        stall_prev;
    logic [31:0] stall_data;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) start_cnt++;
      if (stall_prev && out_valid === 1'b1) check("out_data_held", out_data, stall_data);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected no word", out_data);
        end else begin
          check("out_word", out_data, exp_q.pop_front());
        end
      end
      stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
      stall_data = out_data;
    end
  end

  initial begin
    int rc;
    rc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ((rc % 4 == 0) || (rc % 4 == 3));
      rc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic load_op(input int gap, input bit expect_start);
    int s_begin;
    s_begin = start_cnt;
    for (int i = 0; i < 28; i++) begin
      int guard;
      guard = 0;
      in_data  = in_words[i];
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (in_ready !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout word %0d: got 0 expected 1", i);
        in_valid = 1'b0;
        return;
      end
      if (i == 27) check("no_early_start", start_cnt, s_begin);
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 27) repeat (gap) @(negedge clk);
    end
    check("start_after_word28", core_start, expect_start);
    if (expect_start) begin
      @(negedge clk);
      check("start_one_cycle", core_start, 1'b0);
    end
  endtask

  task automatic finish_op(input int dly);
    int hs0;
    int guard;
    repeat (dly) @(negedge clk);
    check("no_out_before_done", out_valid, 1'b0);
    hs0 = hs_cnt;
    core_out = build_out();
    for (int i = 0; i < 42; i++)
      exp_q.push_back((i % 7 == 6) ? {30'b0, res_words[i][1:0]} : res_words[i]);
    core_done = 1'b1;
    @(negedge clk);
    check("out_valid_latency", out_valid, 1'b1);
    core_done = 1'b0;
    guard = 0;
    while (!(exp_q.size() == 0 && out_valid === 1'b0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("handshakes", hs_cnt - hs0, 42);
    check("queue_drained", exp_q.size(), 0);
    check("in_ready_after_unload", in_ready, 1'b1);
    check("busy_after_unload", busy, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    int s0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    core_done = 1'b0;
    core_out  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_core_xp", core_xp, 194'h0);
    check("rst_core_yr", core_yr, 194'h0);

    // Gapless load, free-running sink; first out word and 7th word from the reference vector.
    set_operands(4'h0);
    set_results(32'h0);
    res_words[0] = 32'h41612219;
    res_words[6] = 32'h00000001;
    load_op(0, 1'b1);
    check("xp", core_xp, pack_elem(0));
    check("yp", core_yp, pack_elem(1));
    check("xr", core_xr, pack_elem(2));
    check("yr", core_yr, pack_elem(3));
    check("xp_word0", core_xp[31:0], 32'hA5100012);
    check("yr_top", core_yr[193:192], 2'b10);
    check("busy_in_wait", busy, 1'b1);
    check("in_ready_in_wait", in_ready, 1'b0);
    finish_op(3);

    // Same operands with in_valid every third cycle; sink ready 1,0,0,1.
    ready_mode = 1;
    set_results(32'h5A5A0F0F);
    load_op(2, 1'b1);
    check("gap_xp", core_xp, pack_elem(0));
    check("gap_yp", core_yp, pack_elem(1));
    check("gap_xr", core_xr, pack_elem(2));
    check("gap_yr", core_yr, pack_elem(3));
    finish_op(2);
    ready_mode = 0;

    // Reset for one cycle while waiting on the core; a later core_done must be ignored.
    set_operands(4'h9);
    load_op(0, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midwait_in_ready", in_ready, 1'b1);
    check("midwait_busy", busy, 1'b0);
    check("midwait_out_valid", out_valid, 1'b0);
    check("midwait_xp_cleared", core_xp, 194'h0);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (20) @(negedge clk);
    check("midwait_no_output", out_valid, 1'b0);

    // core_done already high when WAIT is entered: only a fresh rising edge counts.
    set_operands(4'h6);
    set_results(32'hC3C3_1234);
    core_done = 1'b1;
    load_op(0, 1'b1);
    repeat (10) @(negedge clk);
    check("held_done_no_out", out_valid, 1'b0);
    check("held_done_busy", busy, 1'b1);
    core_done = 1'b0;
    repeat (2) @(negedge clk);
    finish_op(0);

    // Illegal trit code in xp word 0.
    set_operands(4'h0);
    in_words[0] = 32'h00000003;
    set_results(32'h0BAD_F00D);
    s0 = start_cnt;
`ifdef PAIRING_TRIT_CHECK_EN
    load_op(0, 1'b0);
    check("trit_err", err, 1'b1);
    check("trit_in_ready", in_ready, 1'b1);
    repeat (5) @(negedge clk);
    check("trit_no_start", start_cnt, s0);
    check("trit_no_out", out_valid, 1'b0);
    set_operands(4'h0);
    load_op(0, 1'b1);
    check("trit_err_cleared", err, 1'b0);
    finish_op(1);
`else
    load_op(0, 1'b1);
    check("trit_err_off", err, 1'b0);
    check("trit_start_count", start_cnt - s0, 1);
    finish_op(1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
